// File: rtl/interleaver_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// interleaver_pingpong_buffer
//
// Two-bank ping-pong buffer between a bit interleaver and a symbol modulator.
// The interleaver scatters bits into the write bank by destination index; once
// NCBPS bits have been counted, that bank is handed to the read side. The read
// side then streams NCPC-bit symbols in index order with a valid/ready
// handshake. The lowest bit index of each symbol is placed on the MSB.
//
// Optional feature (compile-time macro BUF_INDEX_CHECK_EN):
//   defined   - writes with data_in_index >= NCBPS still handshake, but are
//               neither stored nor counted, and they set the sticky idx_err.
//   undefined - idx_err is tied low; such writes are counted and their data
//               is dropped.
// -----------------------------------------------------------------------------
module interleaver_pingpong_buffer #(
    parameter int NCBPS = 192,
    parameter int NCPC  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_in,
    input  logic [$clog2(NCBPS)-1:0] data_in_index,
    input  logic                     valid_interleaver,
    output logic                     ready_buffer,
    input  logic                     ready_mod,
    output logic                     valid_buffer,
    output logic [NCPC-1:0]          data_out,
    output logic                     idx_err
);

    localparam int IW   = $clog2(NCBPS);
    localparam int NSYM = NCBPS / NCPC;
    localparam int PW   = (NSYM > 1) ? $clog2(NSYM) : 1;

    localparam logic [IW-1:0] LAST_WR  = IW'(NCBPS - 1);
    localparam logic [PW-1:0] LAST_SYM = PW'(NSYM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Write side state
    logic            wr_sel_reg;
    logic [IW-1:0]   wr_cnt_reg;
    logic [1:0]      full_reg;

    // Read side state
    rd_state_t       state_reg;
    logic            rd_sel_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic            valid_reg;
    logic [NCPC-1:0] data_out_reg;

    // Handshake and bookkeeping strobes
    logic            write_fire;
    logic            index_ok;
    logic            write_counted;
    logic            bank_done;
    logic            sym_fire;
    logic            read_done;

    // Symbol fetch path
    logic [PW-1:0]   load_ptr;
    logic [IW-1:0]   load_base;
    logic [NCPC-1:0] bank_bits [2];
    logic [NCPC-1:0] sym_bits;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    // The write bank can only be full when both banks are full, because the
    // reader drains banks in the same order the writer fills them.
    assign ready_buffer = !full_reg[wr_sel_reg];
    assign write_fire   = valid_interleaver && ready_buffer;
    assign index_ok     = (int'(data_in_index) < NCBPS);
    assign bank_done    = write_counted && (wr_cnt_reg == LAST_WR);

    assign sym_fire     = valid_reg && ready_mod;
    assign read_done    = sym_fire && (rd_ptr_reg == LAST_SYM);

    assign valid_buffer = valid_reg;
    assign data_out     = data_out_reg;

`ifdef BUF_INDEX_CHECK_EN
    logic idx_err_reg;

    // Out-of-range writes are swallowed without advancing the fill count.
    assign write_counted = write_fire && index_ok;
    assign idx_err       = idx_err_reg;

    // Sticky flag for any out-of-range write since the last reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_err_reg <= 1'b0;
        end else if (write_fire && !index_ok) begin
            idx_err_reg <= 1'b1;
        end
    end
`else
    // Out-of-range writes still count toward bank completion; data is lost.
    assign write_counted = write_fire;
    assign idx_err       = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Bank storage: one array per bank, written bit-wise by destination index,
    // read NCPC bits at a time. The read result is captured in data_out_reg.
    // -------------------------------------------------------------------------
    // Pointer of the symbol to be presented after the coming edge: symbol 0
    // when leaving IDLE, otherwise the successor of the current symbol.
    always_comb begin
        load_ptr = '0;
        if (state_reg == READ) begin
            load_ptr = rd_ptr_reg + 1'b1;
        end
    end

    assign load_base = IW'(load_ptr) * IW'(NCPC);

    genvar gi, gb;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic mem [NCBPS];

            // Store the incoming bit when this bank is the active write bank.
            always_ff @(posedge clk) begin
                if (!reset && write_fire && index_ok && (wr_sel_reg == 1'(gi))) begin
                    mem[data_in_index] <= data_in;
                end
            end

            // Lowest bit index of the symbol lands on the MSB.
            for (gb = 0; gb < NCPC; gb++) begin : g_sym_bit
                assign bank_bits[gi][NCPC-1-gb] = mem[load_base + IW'(gb)];
            end
        end
    endgenerate

    assign sym_bits = rd_sel_reg ? bank_bits[1] : bank_bits[0];

    // -------------------------------------------------------------------------
    // Write side
    // -------------------------------------------------------------------------
    // Count accepted writes; the last one of a bank flips to the other bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel_reg <= 1'b0;
            wr_cnt_reg <= '0;
        end else if (write_counted) begin
            if (wr_cnt_reg == LAST_WR) begin
                wr_cnt_reg <= '0;
                wr_sel_reg <= ~wr_sel_reg;
            end else begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
        end
    end

    // Full flags: set by bank completion, cleared by the last symbol transfer.
    // Both can happen on one edge; they always target different banks since a
    // full bank never accepts writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_reg <= 2'b00;
        end else begin
            if (read_done) begin
                full_reg[rd_sel_reg] <= 1'b0;
            end
            if (bank_done) begin
                full_reg[wr_sel_reg] <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read side
    // -------------------------------------------------------------------------
    // Read FSM with registered valid/data: waits for a full bank, then streams
    // its symbols, holding output while the modulator stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            rd_sel_reg   <= 1'b0;
            rd_ptr_reg   <= '0;
            valid_reg    <= 1'b0;
            data_out_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg    <= 1'b0;
                    data_out_reg <= '0;
                    rd_ptr_reg   <= '0;
                    if (full_reg[rd_sel_reg]) begin
                        state_reg    <= READ;
                        valid_reg    <= 1'b1;
                        data_out_reg <= sym_bits;
                    end
                end
                READ: begin
                    if (sym_fire) begin
                        if (rd_ptr_reg == LAST_SYM) begin
                            state_reg    <= IDLE;
                            valid_reg    <= 1'b0;
                            data_out_reg <= '0;
                            rd_ptr_reg   <= '0;
                            rd_sel_reg   <= ~rd_sel_reg;
                        end else begin
                            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                            data_out_reg <= sym_bits;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
